boron_dec_core: RTL and testbench



---
 rtl/boron_pkg.sv | 74 +++++++
 rtl/xor_inv_op.sv | 17 +
 rtl/boron_dec_core.sv | 114 +++++++++++
 tb/tb_boron_dec_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boron_pkg.sv
// boron_pkg: shared constants, tables and helper functions for the BORON
// decryption datapath.
//   - ROUNDS / widths and the round-counter width
//   - inverse S-box table, per-word rotation amounts, block shuffle map
//   - FSM state enum (IDLE, ROUND, DONE)
//   - inv_perm / inv_shuffle / inv_sbox helpers used by boron_dec_core
package boron_pkg;

   localparam int ROUNDS = 25;
   localparam int BLK_W  = 64;
   localparam int WORD_W = 16;
   localparam int NWORDS = BLK_W / WORD_W;
   localparam int CNT_W  = 5;

   localparam logic [CNT_W-1:0] ROUNDS_IDX = CNT_W'(ROUNDS);
   localparam logic [CNT_W-1:0] ROUNDS_M1  = CNT_W'(ROUNDS - 1);

   // Inverse S-box, entry n in bits [4n+3:4n].
   // Forward box: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
   // Inverse box: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A
   localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

   // Encryption left-rotation per 16-bit word, word w in bits [4w+3:4w]:
   // word0=1, word1=7, word2=11, word3=13.
   localparam logic [15:0] ROT_AMT = 16'hDB71;

   // Encryption nibble shuffle: out nibble i = in nibble SHUF_MAP[i],
   // entry i in bits [4i+3:4i]. Map is (5*i+3) mod 16.
   localparam logic [63:0] SHUF_MAP = 64'hE94F_A50B_61C7_2D83;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Rotate each word right by its encryption rotation amount.
   function automatic logic [BLK_W-1:0] inv_perm(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0]    y;
      logic [2*WORD_W-1:0] dbl;
      int                  r;
      y = '0;
      for (int w = 0; w < NWORDS; w++) begin
         r   = int'(ROT_AMT[w*4 +: 4]);
         dbl = {x[w*WORD_W +: WORD_W], x[w*WORD_W +: WORD_W]};
         y[w*WORD_W +: WORD_W] = dbl[r +: WORD_W];
      end
      return y;
   endfunction

   // Put every nibble back where the encryption shuffle took it from.
   function automatic logic [BLK_W-1:0] inv_shuffle(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      int               j;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         j = int'(SHUF_MAP[i*4 +: 4]);
         y[j*4 +: 4] = x[i*4 +: 4];
      end
      return y;
   endfunction

   function automatic logic [BLK_W-1:0] inv_sbox(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] y;
      int               n;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         n = int'(x[i*4 +: 4]);
         y[i*4 +: 4] = INV_SBOX[n*4 +: 4];
      end
      return y;
   endfunction

endpackage

// File: rtl/xor_inv_op.sv
// xor_inv_op: combinational inverse of the BORON XOR mixing layer.
// Ports:
//   q : in  [63:0] mixed block, word n = q[16n+15:16n]
//   w : out [63:0] unmixed block
module xor_inv_op
   import boron_pkg::*;
(
   input  logic [BLK_W-1:0] q,
   output logic [BLK_W-1:0] w
);

   logic [WORD_W-1:0] q0, q1, q2, q3;

   assign {q3, q2, q1, q0} = q;
   assign w = {q2 ^ q3, q0 ^ q1 ^ q2, q1 ^ q2 ^ q3, q0 ^ q1};

endmodule

// File: rtl/boron_dec_core.sv
// boron_dec_core: iterative BORON block decryption, one round per cycle,
// round counter runs ROUNDS-1 down to 0.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : request to decrypt ct_i, taken only while idle
//   ct_i         : ciphertext, sampled with the accepted start
//   rk_i         : round key for rk_idx_o, combinational lookup outside
//   rk_idx_o     : round-key index needed this cycle
//   counter_o    : round counter
//   busy_o       : decryption in progress
//   pt_o         : plaintext, held until the next accepted start
//   pt_valid_o   : one-cycle strobe with a new pt_o
//   dbg_state    : FSM state for observation
// Build option: BORON_DEC_PIPE_EN splits every round into two cycles
// (A: InvXor+InvPerm registered, B: InvShuffle+InvSbox+key add).
// Handshake: start_i is a single-cycle request with no ready; it is accepted
// iff the FSM is in IDLE, and the result is announced by pt_valid_o.
module boron_dec_core
   import boron_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [BLK_W-1:0] ct_i,
   input  logic [BLK_W-1:0] rk_i,
   output logic [CNT_W-1:0] rk_idx_o,
   output logic [CNT_W-1:0] counter_o,
   output logic             busy_o,
   output logic [BLK_W-1:0] pt_o,
   output logic             pt_valid_o,
   output state_t           dbg_state
);

   state_t           state;
   logic [BLK_W-1:0] state_reg;
   logic [BLK_W-1:0] xor_w;
   logic [BLK_W-1:0] round_nxt;
   logic             step_en;

   xor_inv_op u_xor_inv (
      .q (state_reg),
      .w (xor_w)
   );

`ifdef BORON_DEC_PIPE_EN
   logic             phase_b;
   logic [BLK_W-1:0] mid_reg;

   assign round_nxt = inv_sbox(inv_shuffle(mid_reg)) ^ rk_i;
   assign step_en   = phase_b;
`else
   assign round_nxt = inv_sbox(inv_shuffle(inv_perm(xor_w))) ^ rk_i;
   assign step_en   = 1'b1;
`endif

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         state_reg  <= '0;
         counter_o  <= '0;
         rk_idx_o   <= ROUNDS_IDX;
         busy_o     <= 1'b0;
         pt_o       <= '0;
         pt_valid_o <= 1'b0;
`ifdef BORON_DEC_PIPE_EN
         phase_b    <= 1'b0;
         mid_reg    <= '0;
`endif
      end else begin
         pt_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state_reg <= ct_i ^ rk_i;   // whitening with K[ROUNDS]
                  counter_o <= ROUNDS_M1;
                  rk_idx_o  <= ROUNDS_M1;
                  busy_o    <= 1'b1;
                  state     <= ROUND;
               end
            end
            ROUND: begin
`ifdef BORON_DEC_PIPE_EN
               phase_b <= ~phase_b;
               if (!phase_b) mid_reg <= inv_perm(xor_w);
`endif
               if (step_en) begin
                  state_reg <= round_nxt;
                  if (counter_o == '0) begin
                     // Last round: publish the result as DONE is entered so
                     // pt_o and pt_valid_o line up in the same cycle.
                     pt_o       <= round_nxt;
                     pt_valid_o <= 1'b1;
                     busy_o     <= 1'b0;
                     rk_idx_o   <= ROUNDS_IDX;
                     state      <= DONE;
                  end else begin
                     counter_o <= counter_o - 1'b1;
                     rk_idx_o  <= counter_o - 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;   // start_i seen here is dropped
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boron_dec_core.sv
`timescale 1ns/1ps
module tb_boron_dec_core;
   import boron_pkg::*;

   localparam int NR = 25;
`ifdef BORON_DEC_PIPE_EN
   localparam int LAT = 2*NR + 1;
`else
   localparam int LAT = NR + 1;
`endif
   localparam int N_RAND = 1000;

   // Forward (encryption-side) reference tables.
   localparam int SBOX_F [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
   localparam int ROT_F  [4]  = '{1, 7, 11, 13};

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [63:0] ct_i;
   logic [63:0] rk_i;
   logic [4:0]  rk_idx_o;
   logic [4:0]  counter_o;
   logic        busy_o;
   logic [63:0] pt_o;
   logic        pt_valid_o;
   state_t      dbg_state;

   logic [63:0] xq;
   logic [63:0] xw;

   logic [63:0] rk_tbl [0:NR];
   logic [63:0] exp_q [$];
   int          total = 0;
   int          bad   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   boron_dec_core dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .ct_i       (ct_i),
      .rk_i       (rk_i),
      .rk_idx_o   (rk_idx_o),
      .counter_o  (counter_o),
      .busy_o     (busy_o),
      .pt_o       (pt_o),
      .pt_valid_o (pt_valid_o),
      .dbg_state  (dbg_state)
   );

   xor_inv_op u_xinv (
      .q (xq),
      .w (xw)
   );

   // Key-schedule stand-in: combinational lookup of the requested index.
   assign rk_i = (int'(rk_idx_o) <= NR) ? rk_tbl[rk_idx_o] : 64'h0;

   // ---------------- reference model ----------------
   function automatic logic [63:0] fwd_sbox(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[i*4 +: 4] = 4'(SBOX_F[int'(x[i*4 +: 4])]);
      return y;
   endfunction

   function automatic logic [63:0] fwd_shuf(input logic [63:0] x);
      logic [63:0] y;
      int          src;
      for (int i = 0; i < 16; i++) begin
         src = (5*i + 3) % 16;
         y[i*4 +: 4] = x[src*4 +: 4];
      end
      return y;
   endfunction

   function automatic logic [15:0] rotl16(input logic [15:0] x, input int r);
      return (x << r) | (x >> (16 - r));
   endfunction

   function automatic logic [63:0] fwd_perm(input logic [63:0] x);
      logic [63:0] y;
      for (int w = 0; w < 4; w++) y[w*16 +: 16] = rotl16(x[w*16 +: 16], ROT_F[w]);
      return y;
   endfunction

   // Forward mix: Q0=W0^W1^W3, Q1=W1^W3, Q2=W0^W2, Q3=W0^W2^W3.
   function automatic logic [63:0] fwd_xor(input logic [63:0] x);
      logic [15:0] w0, w1, w2, w3;
      {w3, w2, w1, w0} = x;
      return {w0 ^ w2 ^ w3, w0 ^ w2, w1 ^ w3, w0 ^ w1 ^ w3};
   endfunction

   function automatic logic [63:0] encrypt(input logic [63:0] pt);
      logic [63:0] s;
      s = pt;
      for (int r = 0; r < NR; r++) s = fwd_xor(fwd_perm(fwd_shuf(fwd_sbox(s ^ rk_tbl[r]))));
      return s ^ rk_tbl[NR];
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && pt_valid_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pt_strobe: got strobe with pt_o=%h expected no strobe", pt_o);
         end else begin
            check("pt_o", pt_o, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy_o || pt_valid_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
      end
   endtask

   task automatic load_keys();
      for (int k = 0; k <= NR; k++) rk_tbl[k] = {$urandom, $urandom};
   endtask

   // Leaves start_i high at a negedge; caller lowers it on the next one.
   task automatic launch(input logic [63:0] pt, input bit push);
      wait_idle();
      load_keys();
      ct_i = encrypt(pt);
      if (push) exp_q.push_back(pt);
      start_i = 1'b1;
   endtask

   task automatic issue(input logic [63:0] pt, input bit push);
      launch(pt, push);
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Cycle-exact trace of one decryption, with stray starts while busy and
   // in the DONE cycle.
   task automatic lat_test();
      logic [63:0] pt;
      int          exp_idx;
      pt = {$urandom, $urandom};
      launch(pt, 1'b1);
      check("rk_idx_start", 64'(rk_idx_o), 64'(NR));
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         start_i = 1'b0;
         check("busy", 64'(busy_o), 64'(k < LAT));
         check("pt_valid", 64'(pt_valid_o), 64'(k == LAT));
         if (k < LAT) begin
`ifdef BORON_DEC_PIPE_EN
            exp_idx = NR - (k + 1) / 2;
`else
            exp_idx = NR - k;
`endif
            check("rk_idx", 64'(rk_idx_o), 64'(exp_idx));
            check("counter", 64'(counter_o), 64'(exp_idx));
         end
         if (k > LAT) check("pt_hold", pt_o, pt);
         if (k == 5 || k == LAT) start_i = 1'b1;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      rst     = 1'b1;
      start_i = 1'b0;
      ct_i    = '0;
      for (int k = 0; k <= NR; k++) rk_tbl[k] = '0;

      // Inverse mix layer on its own.
      xq = 64'h0000_0000_0000_0001;
      #1;
      check("xinv_vec", xw, 64'h0000_0001_0000_0001);
      for (int i = 0; i < 64; i++) begin
         xq = fwd_xor(64'h1 << i);
         #1;
         check("xinv_roundtrip", xw, 64'h1 << i);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy_o), 64'h0);
      check("rst_valid", 64'(pt_valid_o), 64'h0);
      check("rst_pt", pt_o, 64'h0);
      check("rst_counter", 64'(counter_o), 64'h0);
      check("rst_rk_idx", 64'(rk_idx_o), 64'(NR));
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      rst = 1'b0;

      lat_test();

      // Reset in the middle of a decryption: no strobe, everything cleared.
      issue({$urandom, $urandom}, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", 64'(busy_o), 64'h0);
      check("mid_rst_pt", pt_o, 64'h0);
      check("mid_rst_counter", 64'(counter_o), 64'h0);
      check("mid_rst_valid", 64'(pt_valid_o), 64'h0);
      check("mid_rst_rk_idx", 64'(rk_idx_o), 64'(NR));
      rst = 1'b0;
      lat_test();

      // Boundary blocks, then random blocks with random idle gaps.
      issue(64'h0, 1'b1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      for (int t = 0; t < N_RAND; t++) begin
         issue({$urandom, $urandom}, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("queue_drain", 64'(exp_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
